// File: rtl/coin_acceptor_if.sv
// Sensor/dispense/coin-code bundle between the coin acceptor and its neighbours.
// The slave side is the acceptor; the master side is the sensor/vending-FSM end.
interface coin_acceptor_if;
   logic       nickel_in;
   logic       dime_in;
   logic       nw_pa;
   logic [1:0] coin;
   logic       reject;

   modport master (output nickel_in, dime_in, nw_pa, input coin, reject);
   modport slave  (input nickel_in, dime_in, nw_pa, output coin, reject);
endinterface

// File: rtl/coin_acceptor.sv
// Debounces two asynchronous coin sensors into single-cycle coin codes for the
// vending FSM, flags double insertions, and holds a coin back during dispense.
module coin_acceptor #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int CNT_W        = 4
) (
   input  logic            clk,
   input  logic            rst,
   coin_acceptor_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, QUALIFY, PEND, RELEASE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       nsync_q, dsync_q;
   logic [1:0]       pat;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cap_q, cap_d;
   logic [1:0]       coin_q, coin_d;
   logic             reject_q, reject_d;

   assign pat = {dsync_q[1], nsync_q[1]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cap_d    = cap_q;
      coin_d   = 2'b00;
      reject_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pat != 2'b00) begin
               cap_d   = pat;
               cnt_d   = CNT_ONE;
               state_d = QUALIFY;
            end
         end
         QUALIFY: begin
            if (pat == 2'b00) begin
               state_d = IDLE;
            end else if (pat != cap_q) begin
               cap_d = pat;
               cnt_d = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               // This matching sample is the DEBOUNCE_CYC-th one: qualified.
               cnt_d = '0;
               if (cap_q == 2'b11) begin
                  reject_d = 1'b1;
                  state_d  = RELEASE;
               end else if (bus.nw_pa) begin
                  state_d = PEND;
               end else begin
                  coin_d  = cap_q;
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PEND: begin
            if (!bus.nw_pa) begin
               coin_d  = cap_q;
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Only a full run of clean low samples re-arms; bounces restart it.
            if (pat != 2'b00) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nsync_q  <= 2'b00;
         dsync_q  <= 2'b00;
         state_q  <= IDLE;
         cnt_q    <= '0;
         cap_q    <= 2'b00;
         coin_q   <= 2'b00;
         reject_q <= 1'b0;
      end else begin
         nsync_q  <= {nsync_q[0], bus.nickel_in};
         dsync_q  <= {dsync_q[0], bus.dime_in};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cap_q    <= cap_d;
         coin_q   <= coin_d;
         reject_q <= reject_d;
      end
   end

   assign bus.coin   = coin_q;
   assign bus.reject = reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected pulses (edge, code, reject) are
// queued as stimulus is driven and matched by a monitor whenever an output fires.
module tb_coin_acceptor;
   localparam int D = 4;

   typedef struct {
      int unsigned edge_n;
      logic [1:0]  coin;
      logic        rej;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   vecs = 0;
   int   errs = 0;
   ev_t  exq[$];

   coin_acceptor_if bus ();

   coin_acceptor #(.DEBOUNCE_CYC(D), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic n, input logic d);
      bus.nickel_in = n;
      bus.dime_in   = d;
   endtask

   // off = edges after E, where E is the next rising edge (first raw sample).
   task automatic expect_at(input int off, input logic [1:0] c, input logic r);
      ev_t e;
      e.edge_n = 32'(cyc + 1 + off);
      e.coin   = c;
      e.rej    = r;
      exq.push_back(e);
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (exq.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(exq.size()), 32'd0);
      tick(20);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (rst && (bus.coin !== 2'b00 || bus.reject !== 1'b0)) begin
         if (exq.size() == 0) begin
            chk("extra_pulse_coin", {30'b0, bus.coin}, 32'd0);
            chk("extra_pulse_reject", {31'b0, bus.reject}, 32'd0);
         end else begin
            e = exq.pop_front();
            chk("pulse_edge", 32'(cyc), e.edge_n);
            chk("pulse_coin", {30'b0, bus.coin}, {30'b0, e.coin});
            chk("pulse_reject", {31'b0, bus.reject}, {31'b0, e.rej});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      drive(1'b0, 1'b0);
      bus.nw_pa = 1'b0;
      tick(1);
      chk("reset_coin", {30'b0, bus.coin}, 32'd0);
      chk("reset_reject", {31'b0, bus.reject}, 32'd0);
      tick(2);
      rst = 1'b1;

      // Nickel first sampled at edge 10 -> coin=01 at edge 15 only.
      while (cyc < 9) tick(1);
      expect_at(D + 1, 2'b01, 1'b0);
      drive(1'b1, 1'b0);
      tick(12);
      drive(1'b0, 1'b0);
      drain("nickel_drain");

      // Short dime is a glitch; a 6-cycle dime counts.
      drive(1'b0, 1'b1);
      tick(3);
      drive(1'b0, 1'b0);
      tick(10);
      expect_at(D + 1, 2'b10, 1'b0);
      drive(1'b0, 1'b1);
      tick(6);
      drive(1'b0, 1'b0);
      drain("dime_drain");

      // Both sensors together -> reject only.
      expect_at(D + 1, 2'b00, 1'b1);
      drive(1'b1, 1'b1);
      tick(8);
      drive(1'b0, 1'b0);
      drain("reject_drain");

      // Dispense in progress across qualification: coin deferred to edge E+10.
      expect_at(10, 2'b10, 1'b0);
      bus.nw_pa = 1'b1;
      drive(1'b0, 1'b1);
      tick(8);
      drive(1'b0, 1'b0);
      tick(2);
      bus.nw_pa = 1'b0;
      drain("pend_drain");

      // Bounce after qualification yields a single coin.
      expect_at(D + 1, 2'b10, 1'b0);
      drive(1'b0, 1'b1);
      tick(6);
      drive(1'b0, 1'b0);
      tick(2);
      drive(1'b0, 1'b1);
      tick(3);
      drive(1'b0, 1'b0);
      drain("bounce_drain");

      // Only 3 low samples before a nickel: still releasing, nickel swallowed.
      expect_at(D + 1, 2'b10, 1'b0);
      drive(1'b0, 1'b1);
      tick(6);
      drive(1'b0, 1'b0);
      tick(3);
      drive(1'b1, 1'b0);
      tick(6);
      drive(1'b0, 1'b0);
      tick(20);
      chk("swallow_queue", 32'(exq.size()), 32'd0);
      expect_at(D + 1, 2'b01, 1'b0);
      drive(1'b1, 1'b0);
      tick(6);
      drive(1'b0, 1'b0);
      drain("rearm_drain");

      // Reset in QUALIFY with nickel held: discard, then one fresh coin.
      drive(1'b1, 1'b0);
      tick(3);
      rst = 1'b0;
      #1;
      chk("qual_rst_coin", {30'b0, bus.coin}, 32'd0);
      chk("qual_rst_reject", {31'b0, bus.reject}, 32'd0);
      tick(3);
      expect_at(D + 1, 2'b01, 1'b0);
      rst = 1'b1;
      tick(6);
      drive(1'b0, 1'b0);
      drain("post_rst_drain");

      // Asynchronous reset clears a live coin pulse without a clock edge.
      drive(1'b1, 1'b0);
      repeat (D + 2) @(posedge clk);
      #1;
      chk("live_coin", {30'b0, bus.coin}, 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_coin", {30'b0, bus.coin}, 32'd0);
      chk("async_rst_reject", {31'b0, bus.reject}, 32'd0);
      tick(1);
      drive(1'b0, 1'b0);
      tick(2);
      rst = 1'b1;
      tick(15);

      chk("final_queue", 32'(exq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
